sha1_ctrl: RTL
==============

# sha1_ctrl

Sequencing controller for the single-round SHA-1 datapath (one round per clock, 16-word Wt shift register). It reads a message from a word-addressed synchronous memory and applies FIPS 180-4 padding on the fly. It runs 80 rounds per 512-bit block, accumulates H0..H4, and writes the 160-bit digest back to memory. It sits between the system memory port and the round datapath, and is the only master of that memory port while busy.

## Interface
Parameters:
- ADDR_W, 16: memory word-address width.
- SIZE_W, 16: width of message_size.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- message_addr  in  ADDR_W  word address of message word 0.
- output_addr  in  ADDR_W  word address of digest word H0.
- message_size  in  SIZE_W  message length in bytes (in blocks when padding is compiled out).
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  write enable.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  read data, valid one cycle after its address is presented.
- busy  out  1  high from the cycle after start is accepted through the DONE state.
- done  out  1  one-cycle completion pulse.

## Operation
Message layout:
- Big-endian. Byte 4i is in bits [31:24] of word i.

States: IDLE -> READ -> COMPUTE -> UPDATE -> (READ | WRITE) -> DONE -> IDLE.
- IDLE
  - start=1 latches message_addr, output_addr and message_size, and loads H0..H4 with the IV (67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0).
  - blk is cleared to 0.
- READ (17 cycles, r=0..16)
  - Cycles r=0..15 present mem_addr = message_addr + 16*blk + r.
  - Cycles r=1..16 capture mem_read_data into w[r-1]. The padding substitution below is applied first.
  - Reads are always issued, even for words that lie wholly inside the padding.
  - At r=16, a..e are loaded from H0..H4.
- Padding substitution, per byte at global byte index j = 64*blk + 4*word + lane:
  - j < size: byte kept.
  - j = size: byte becomes 0x80.
  - Otherwise: byte becomes 0x00.
  - In the last block, words 14 and 15 are replaced by the 64-bit value {size, 3'b0}, zero-extended.
- Block count: nblk = (size + 8) / 64 + 1, using integer division.
- COMPUTE (80 cycles, t=0..79)
  - One round per cycle: {a,b,c,d,e} <= {rotl5(a)+f(t)+e+K(t)+Wt, a, rotl30(b), c, d}.
  - Wt = w[t] for t<16. For t>=16, Wt = rotl1(w[t-3]^w[t-8]^w[t-14]^w[t-16]), held in a 16-entry shift window.
  - All additions are modulo 2^32.
- UPDATE (1 cycle)
  - Hi <= Hi + {a..e}i, modulo 2^32.
  - blk increments.
  - Go to READ if blk+1 < nblk, otherwise to WRITE.
- WRITE (5 cycles, i=0..4): mem_we=1, mem_addr=output_addr+i, mem_write_data=Hi.
- DONE (1 cycle): done=1, then IDLE.

Boundary rules:
- start while busy is ignored; the latched inputs are unchanged.
- Input changes after acceptance have no effect.
- size 55 gives 1 block; sizes 56 and 64 give 2 blocks; size 0 gives 1 block.
- mem_addr wraps modulo 2^ADDR_W.
- Reset mid-operation returns the block to IDLE immediately, with no partial writes completed afterward.

## Timing
Reset values:
- mem_we=0, done=0, busy=0, mem_addr=0, mem_write_data=0.
- State is IDLE, H is set to the IV, and t=0.

Latency:
- start sampled at cycle 0 puts the block in READ at cycle 1.
- For N blocks, the WRITE cycles are 98N+1 .. 98N+5.
- done is asserted at cycle 98N+6.
- The next start is accepted at cycle 98N+7 or later.

Outputs:
- mem_we is high in exactly 5 cycles per operation.
- All outputs are registered or decoded directly from the state; there are no combinational paths from mem_read_data to outputs.

## Configuration
SHA1_PAD_EN:
- Defined: hardware padding as described above; message_size is in bytes.
- Undefined:
  - Padding logic is removed. message_size is the number of pre-padded 512-bit blocks and w[] takes mem_read_data unmodified.
  - message_size=0 skips READ, COMPUTE and UPDATE, writes the IV, and asserts done at cycle 6.

## Structure
Shared package sha1_pkg holds:
- State enum typedef.
- IV constants H0_INIT..H4_INIT.
- K constants.
- Functions sha1_f(t,b,c,d), sha1_k(t) and rotl.

Sub-module sha1_round:
- Combinational single round.
- Inputs: a..e, Wt, t. Output: next a..e.
- Instantiated once so the critical path can be evaluated in isolation.

The padding mux and block counter stay in sha1_ctrl.

## Test plan
- "abc", size 3 -> digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d at output_addr..+4; done at cycle 104.
- Empty message, size 0 -> da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709; done at cycle 104.
- 56-byte "abcdbcdecdef...nopq" -> 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1; 2 blocks; done at cycle 202.
- Sizes 55, 63 and 64 of repeated 'a' -> digests match the software model; block counts are 1, 2 and 2.
- start pulsed at cycle 50 during the "abc" run -> ignored; single digest, a single done pulse, and exactly 5 writes.
- reset_n low at cycle 60, then "abc" restarted -> no writes before the restart; the correct digest is produced; busy=0 and done=0 during reset.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared types, constants and round helper functions for the SHA-1 controller.
package sha1_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_COMPUTE, S_UPDATE, S_WRITE, S_DONE
  } state_t;

  // Working variables a..e (also used for the H0..H4 accumulator)
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
  } sha1_st_t;

  localparam logic [31:0] H0_INIT = 32'h67452301;
  localparam logic [31:0] H1_INIT = 32'hEFCDAB89;
  localparam logic [31:0] H2_INIT = 32'h98BADCFE;
  localparam logic [31:0] H3_INIT = 32'h10325476;
  localparam logic [31:0] H4_INIT = 32'hC3D2E1F0;

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  localparam sha1_st_t IV = '{a: H0_INIT, b: H1_INIT, c: H2_INIT, d: H3_INIT, e: H4_INIT};

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    if (t < 7'd20)      r = (b & c) | (~b & d);
    else if (t < 7'd40) r = b ^ c ^ d;
    else if (t < 7'd60) r = (b & c) | (b & d) | (c & d);
    else                r = b ^ c ^ d;
    return r;
  endfunction

  function automatic logic [31:0] sha1_k(input logic [6:0] t);
    logic [31:0] r;
    if (t < 7'd20)      r = K0;
    else if (t < 7'd40) r = K1;
    else if (t < 7'd60) r = K2;
    else                r = K3;
    return r;
  endfunction

endpackage

// File: rtl/sha1_round.sv
// Combinational single SHA-1 round; kept separate so its timing path stands alone.
module sha1_round
  import sha1_pkg::*;
(
  input  sha1_st_t    cur,
  input  logic [31:0] wt,
  input  logic [6:0]  t,
  output sha1_st_t    nxt
);

  logic [31:0] tmp;

  // One compression round: new a from the mixing sum, rest shift down
  always_comb begin
    tmp = rotl(cur.a, 5) + sha1_f(t, cur.b, cur.c, cur.d) + cur.e + sha1_k(t) + wt;
    nxt = '{a: tmp, b: cur.a, c: rotl(cur.b, 30), d: cur.c, e: cur.d};
  end

endmodule

// File: rtl/sha1_ctrl.sv
// SHA-1 sequencing controller: reads message words, pads on the fly, runs
// 80 rounds per block, accumulates H0..H4 and writes the digest back.
// Build option: SHA1_PAD_EN enables hardware padding (message_size in bytes);
// without it message_size counts pre-padded 512-bit blocks.
module sha1_ctrl
  import sha1_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int SIZE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [SIZE_W-1:0] message_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic              busy,
  output logic              done
);

  localparam int BLK_W = SIZE_W + 1;

  state_t            state, state_nxt;
  logic [6:0]        cnt;
  logic [ADDR_W-1:0] maddr_q, oaddr_q;
  logic [BLK_W-1:0]  blk, nblk, nblk_in;
  logic              skip_in;
  sha1_st_t          h_q, st_q, st_nxt;
  logic [31:0]       w_q [16];
  logic [31:0]       w_in, w_new;

`ifdef SHA1_PAD_EN
  logic [SIZE_W-1:0]   size_q;
  logic [3:0]          wi;
  logic [31:0]         jbase, sz32;
  logic [63:0]         len64;
  logic                last_blk;
  logic [3:0][7:0]     pad_b;

  // Blocks needed for message + 0x80 + 64-bit length
  assign nblk_in  = (({1'b0, message_size} + BLK_W'(8)) >> 6) + BLK_W'(1);
  assign skip_in  = 1'b0;
  assign wi       = cnt[3:0] - 4'd1;
  assign jbase    = 32'({blk, 6'b0}) + 32'({wi, 2'b00});
  assign sz32     = 32'(size_q);
  assign len64    = 64'({size_q, 3'b000});
  assign last_blk = (blk + BLK_W'(1) == nblk);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [31:0] j;
    logic [7:0]  b_in;
    assign j    = jbase + 32'(g);
    assign b_in = mem_read_data[31-8*g -: 8];
    assign pad_b[3-g] = (j < sz32) ? b_in : ((j == sz32) ? 8'h80 : 8'h00);
  end

  // Byte-masked word, with the bit length overriding words 14/15 of the last block
  always_comb begin
    w_in = pad_b;
    if (last_blk && wi == 4'd14)      w_in = len64[63:32];
    else if (last_blk && wi == 4'd15) w_in = len64[31:0];
  end
`else
  assign nblk_in = {1'b0, message_size};
  assign skip_in = (message_size == '0);
  assign w_in    = mem_read_data;
`endif

  // Next schedule word; window entry k holds W[t+k]
  assign w_new = rotl(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0], 1);

  sha1_round u_round (
    .cur (st_q),
    .wt  (w_q[0]),
    .t   (cnt),
    .nxt (st_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt      = state;
    mem_addr       = '0;
    mem_we         = 1'b0;
    mem_write_data = '0;
    busy           = (state != S_IDLE);
    done           = (state == S_DONE);
    case (state)
      S_IDLE:    if (start) state_nxt = skip_in ? S_WRITE : S_READ;
      S_READ: begin
        if (cnt < 7'd16) mem_addr = maddr_q + ADDR_W'({blk, 4'b0000}) + ADDR_W'(cnt);
        if (cnt == 7'd16) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: if (cnt == 7'd79) state_nxt = S_UPDATE;
      S_UPDATE:  state_nxt = (blk + BLK_W'(1) < nblk) ? S_READ : S_WRITE;
      S_WRITE: begin
        mem_we   = 1'b1;
        mem_addr = oaddr_q + ADDR_W'(cnt);
        case (cnt)
          7'd0:    mem_write_data = h_q.a;
          7'd1:    mem_write_data = h_q.b;
          7'd2:    mem_write_data = h_q.c;
          7'd3:    mem_write_data = h_q.d;
          7'd4:    mem_write_data = h_q.e;
          default: mem_write_data = '0;
        endcase
        if (cnt == 7'd4) state_nxt = S_DONE;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath: input latch, phase counter, Wt window, working vars, H accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      maddr_q <= '0;
      oaddr_q <= '0;
      blk     <= '0;
      nblk    <= '0;
      h_q     <= IV;
      st_q    <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
`ifdef SHA1_PAD_EN
      size_q  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            maddr_q <= message_addr;
            oaddr_q <= output_addr;
            nblk    <= nblk_in;
            blk     <= '0;
            h_q     <= IV;
`ifdef SHA1_PAD_EN
            size_q  <= message_size;
`endif
          end
        end
        S_READ: begin
          if (cnt != 7'd0) begin
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
            w_q[15] <= w_in;
          end
          if (cnt == 7'd16) begin
            cnt  <= '0;
            st_q <= h_q;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        S_COMPUTE: begin
          st_q <= st_nxt;
          for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_new;
          cnt <= (cnt == 7'd79) ? 7'd0 : cnt + 7'd1;
        end
        S_UPDATE: begin
          h_q <= '{a: h_q.a + st_q.a, b: h_q.b + st_q.b, c: h_q.c + st_q.c,
                   d: h_q.d + st_q.d, e: h_q.e + st_q.e};
          blk <= blk + BLK_W'(1);
          cnt <= '0;
        end
        S_WRITE:   cnt <= (cnt == 7'd4) ? 7'd0 : cnt + 7'd1;
        default:   cnt <= '0;
      endcase
    end
  end

endmodule
